mc_main_ctrl: RTL and testbench

Multi-cycle main control FSM for the MIPS CPU. It decodes the 6-bit opcode from the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back steps. It drives the 2-bit `ALUOp` consumed by the ALU control decoder, plus all datapath enables. It stalls on a simple memory ready handshake.

---
 rtl/mc_main_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// and decodes the datapath enables and ALUOp from the current state.
module mc_main_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       BadOp,
    output logic       InstrDone
);

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    localparam logic [1:0] lwOP    = 2'b00;
    localparam logic [1:0] swOP    = 2'b01;
    localparam logic [1:0] RtypeOP = 2'b10;
    localparam logic [1:0] beqOP   = 2'b11;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RTWB   = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

    state_t state_r;
    logic   badop_r;

    logic       pcwrite_s, pcwritecond_s, iord_s, memread_s, memwrite_s, irwrite_s;
    logic       memtoreg_s, regdst_s, regwrite_s, alusrca_s, instrdone_s;
    logic [1:0] alusrcb_s, pcsource_s, aluop_s;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

    // State sequencing and the sticky illegal-opcode flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
            badop_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH:   state_r <= MemReady ? DECODE : FETCH;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state_r <= MEMADR;
                        OP_R:         state_r <= EXEC;
                        OP_BEQ:       state_r <= BRANCH;
                        OP_J:         state_r <= JUMP;
                        default:      state_r <= FETCH;
                    endcase
                    if (!op_legal(Op)) begin
                        badop_r <= 1'b1;
                    end
                end
                MEMADR:  state_r <= (Op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   state_r <= MemReady ? MEMWB : MEMRD;
                MEMWR:   state_r <= MemReady ? FETCH : MEMWR;
                EXEC:    state_r <= RTWB;
                MEMWB, RTWB, BRANCH, JUMP: state_r <= FETCH;
                default: state_r <= FETCH;
            endcase
        end
    end

    // Per-state control decode; unlisted outputs and unreachable encodings stay 0.
    always_comb begin
        pcwrite_s     = 1'b0;
        pcwritecond_s = 1'b0;
        iord_s        = 1'b0;
        memread_s     = 1'b0;
        memwrite_s    = 1'b0;
        irwrite_s     = 1'b0;
        memtoreg_s    = 1'b0;
        regdst_s      = 1'b0;
        regwrite_s    = 1'b0;
        alusrca_s     = 1'b0;
        alusrcb_s     = 2'b00;
        pcsource_s    = 2'b00;
        aluop_s       = lwOP;
        instrdone_s   = 1'b0;
        case (state_r)
            FETCH: begin
                memread_s = 1'b1;
                alusrcb_s = 2'b01;
                irwrite_s = MemReady;
                pcwrite_s = MemReady;
            end
            DECODE: begin
                alusrcb_s   = 2'b11;
                instrdone_s = !op_legal(Op);
            end
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (Op == OP_LW) begin
                    aluop_s = lwOP;
                end else begin
                    aluop_s = swOP;
                end
            end
            MEMRD: begin
                memread_s = 1'b1;
                iord_s    = 1'b1;
            end
            MEMWB: begin
                regwrite_s  = 1'b1;
                memtoreg_s  = 1'b1;
                instrdone_s = 1'b1;
            end
            MEMWR: begin
                memwrite_s  = 1'b1;
                iord_s      = 1'b1;
                instrdone_s = MemReady;
            end
            EXEC: begin
                alusrca_s = 1'b1;
                aluop_s   = RtypeOP;
            end
            RTWB: begin
                regwrite_s  = 1'b1;
                regdst_s    = 1'b1;
                instrdone_s = 1'b1;
            end
            BRANCH: begin
                alusrca_s     = 1'b1;
                aluop_s       = beqOP;
                pcwritecond_s = 1'b1;
                pcsource_s    = 2'b01;
                instrdone_s   = 1'b1;
            end
            JUMP: begin
                pcwrite_s   = 1'b1;
                pcsource_s  = 2'b10;
                instrdone_s = 1'b1;
            end
            default: begin
                aluop_s = lwOP;
            end
        endcase
    end

    // Reset gates the decode directly so a mid-instruction reset kills strobes at once.
    assign PCWrite     = rst_n & pcwrite_s;
    assign PCWriteCond = rst_n & pcwritecond_s;
    assign IorD        = rst_n & iord_s;
    assign MemRead     = rst_n & memread_s;
    assign MemWrite    = rst_n & memwrite_s;
    assign IRWrite     = rst_n & irwrite_s;
    assign MemtoReg    = rst_n & memtoreg_s;
    assign RegDst      = rst_n & regdst_s;
    assign RegWrite    = rst_n & regwrite_s;
    assign ALUSrcA     = rst_n & alusrca_s;
    assign ALUSrcB     = rst_n ? alusrcb_s  : 2'b00;
    assign PCSource    = rst_n ? pcsource_s : 2'b00;
    assign ALUOp       = rst_n ? aluop_s    : 2'b00;
    assign BadOp       = rst_n & badop_r;
    assign InstrDone   = rst_n & instrdone_s;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed scoreboard bench for mc_main_ctrl: expected control vectors are queued
// as each cycle's inputs are driven and compared at the following falling edge.
module tb_mc_main_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, BadOp, InstrDone;
    logic [1:0] ALUSrcB, PCSource, ALUOp;

    int checks = 0;
    int fails  = 0;
    logic bad_exp = 1'b0;
    logic [17:0] exp_q[$];
    string       tag_q[$];

    mc_main_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .BadOp(BadOp), .InstrDone(InstrDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Layout: pcw pcwc iord mrd mwr irw m2r rdst rw srca srcb[2] pcs[2] aluop[2] badop done
    wire [17:0] obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                       ALUOp, BadOp, InstrDone};

    function automatic logic [17:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                       input logic mrd, input logic mwr, input logic irw,
                                       input logic m2r, input logic rdst, input logic rw,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [1:0] pcs, input logic [1:0] aop,
                                       input logic done);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs, aop, 1'b0, done};
    endfunction

    localparam logic [17:0] ZERO   = 18'h0;
    localparam logic [17:0] F_WAIT = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
    localparam logic [17:0] F_RDY  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
    localparam logic [17:0] DEC    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0);
    localparam logic [17:0] DEC_BAD= mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1);
    localparam logic [17:0] MA_LW  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0);
    localparam logic [17:0] MA_SW  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b01,1'b0);
    localparam logic [17:0] MRD    = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    localparam logic [17:0] MWB    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1);
    localparam logic [17:0] MWR_W  = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    localparam logic [17:0] MWR_D  = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1);
    localparam logic [17:0] EXE    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0);
    localparam logic [17:0] RTW    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1);
    localparam logic [17:0] BR     = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b11,1'b1);
    localparam logic [17:0] JMP    = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b1);

    task automatic push(input logic [17:0] e, input string tag);
        exp_q.push_back(e | {16'h0, bad_exp, 1'b0});
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        logic [17:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%05h expected=%05h", t, obs, e);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, check at the falling edge.
    task automatic cyc(input logic mr, input logic [5:0] op, input logic [17:0] e, input string tag);
        MemReady = mr;
        Op       = op;
        push(e, tag);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        MemReady = 1'b1;
        Op       = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        push(ZERO, "reset_outputs");
        check_now();
        rst_n = 1'b1;

        // lw, no stalls: 5 cycles
        cyc(1'b1, 6'h23, F_RDY, "lw_fetch");
        cyc(1'b1, 6'h23, DEC,   "lw_decode");
        cyc(1'b1, 6'h23, MA_LW, "lw_memadr");
        cyc(1'b1, 6'h23, MRD,   "lw_memrd");
        cyc(1'b1, 6'h23, MWB,   "lw_memwb");

        // R-type then beq back to back; MemReady low where it must be ignored
        cyc(1'b1, 6'h00, F_RDY, "r_fetch");
        cyc(1'b0, 6'h00, DEC,   "r_decode");
        cyc(1'b0, 6'h00, EXE,   "r_exec");
        cyc(1'b1, 6'h00, RTW,   "r_rtwb");
        cyc(1'b1, 6'h04, F_RDY, "beq_fetch");
        cyc(1'b1, 6'h04, DEC,   "beq_decode");
        cyc(1'b0, 6'h04, BR,    "beq_branch");

        // sw with three wait cycles in MEMWR: 7 cycles
        cyc(1'b1, 6'h2b, F_RDY, "sw_fetch");
        cyc(1'b1, 6'h2b, DEC,   "sw_decode");
        cyc(1'b1, 6'h2b, MA_SW, "sw_memadr");
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'h2b, MWR_W, "sw_memwr_wait");
        cyc(1'b1, 6'h2b, MWR_D, "sw_memwr_done");

        // Fetch stall of two cycles, then a jump
        cyc(1'b0, 6'h02, F_WAIT, "fetch_wait1");
        cyc(1'b0, 6'h02, F_WAIT, "fetch_wait2");
        cyc(1'b1, 6'h02, F_RDY,  "fetch_ready");
        cyc(1'b1, 6'h02, DEC,    "j_decode");
        cyc(1'b1, 6'h02, JMP,    "j_jump");

        // Illegal opcode: 2 cycles, then BadOp sticks across a valid jump
        cyc(1'b1, 6'h3f, F_RDY,   "bad_fetch");
        cyc(1'b1, 6'h3f, DEC_BAD, "bad_decode");
        bad_exp = 1'b1;
        cyc(1'b1, 6'h02, F_RDY, "sticky_fetch");
        cyc(1'b1, 6'h02, DEC,   "sticky_decode");
        cyc(1'b1, 6'h02, JMP,   "sticky_jump");

        // lw with two wait cycles in MEMRD
        cyc(1'b1, 6'h23, F_RDY, "lw2_fetch");
        cyc(1'b1, 6'h23, DEC,   "lw2_decode");
        cyc(1'b1, 6'h23, MA_LW, "lw2_memadr");
        cyc(1'b0, 6'h23, MRD,   "lw2_memrd_wait1");
        cyc(1'b0, 6'h23, MRD,   "lw2_memrd_wait2");
        cyc(1'b1, 6'h23, MRD,   "lw2_memrd_done");
        cyc(1'b1, 6'h23, MWB,   "lw2_memwb");

        // Asynchronous reset while stalled in MEMRD
        cyc(1'b1, 6'h23, F_RDY, "rst_fetch");
        cyc(1'b1, 6'h23, DEC,   "rst_decode");
        cyc(1'b1, 6'h23, MA_LW, "rst_memadr");
        cyc(1'b0, 6'h23, MRD,   "rst_memrd_wait");
        #2;
        rst_n   = 1'b0;
        bad_exp = 1'b0;
        #1;
        push(ZERO, "async_reset_outputs");
        check_now();
        @(posedge clk);
        #1;
        push(ZERO, "held_reset_outputs");
        check_now();
        rst_n = 1'b1;
        cyc(1'b1, 6'h04, F_RDY, "post_rst_fetch");
        cyc(1'b1, 6'h04, DEC,   "post_rst_decode");
        cyc(1'b1, 6'h04, BR,    "post_rst_branch");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
